// File: rtl/hyperbus_cal_pkg.sv
// Shared types for the HyperBus RWDS/data delay-line calibration controller.
package hyperbus_cal_pkg;

  localparam int NUM_TAPS = 4;

  typedef logic [1:0]          delay_t;
  typedef logic [NUM_TAPS-1:0] mask_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_PROBE,
    ST_NEXT,
    ST_SELECT
  } cal_state_e;

endpackage

// File: rtl/hyperbus_cal_window_sel.sv
// Picks the centre tap of the longest contiguous run of passing taps (lowest start wins ties,
// no wrap-around, centre rounds toward the lower tap).
module hyperbus_cal_window_sel
  import hyperbus_cal_pkg::*;
(
  input  mask_t  mask_i,
  output logic   valid_o,
  output delay_t tap_o
);

  logic [2:0] best_len;
  logic [2:0] len;
  delay_t     best_start;
  logic       run;

  always_comb begin
    best_len   = '0;
    best_start = '0;
    len        = '0;
    run        = 1'b0;
    for (int s = 0; s < NUM_TAPS; s++) begin
      len = '0;
      run = 1'b1;
      for (int k = s; k < NUM_TAPS; k++) begin
        if (run && mask_i[k]) len = len + 3'd1;
        else                  run = 1'b0;
      end
      // Strict compare keeps the earliest start on equal lengths.
      if (len > best_len) begin
        best_len   = len;
        best_start = 2'(s);
      end
    end
    valid_o = (best_len != 3'd0);
    tap_o   = best_start + 2'((best_len - 3'd1) >> 1);
  end

endmodule

// File: rtl/hyperbus_delay_cal.sv
// Delay-tap sweep and window-centre calibration for the HyperBus PHY.
// Optional manual tap override is built when HYPERBUS_DELAY_CAL_OVERRIDE_EN is defined.
module hyperbus_delay_cal
  import hyperbus_cal_pkg::*;
#(
  parameter int     SETTLE_CYCLES = 16,
  parameter int     SAMPLES       = 8,
  parameter delay_t DEFAULT_DELAY = 2'b01
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       ovr_en_i,
  input  logic [1:0] ovr_delay_i,
  output logic       probe_req_o,
  input  logic       probe_valid_i,
  input  logic       probe_pass_i,
  output delay_t     delay_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output mask_t      pass_mask_o
);

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLES_LAST = 8'(SAMPLES - 1);

  cal_state_e state, state_d;
  delay_t     tap_idx, tap_idx_d;
  logic [7:0] settle_cnt, settle_cnt_d;
  logic [7:0] sample_cnt, sample_cnt_d;
  delay_t     saved_delay, saved_delay_d;
  mask_t      mask_d;
  delay_t     delay_d;
  logic       req_d, busy_d, done_d, error_d;
  logic       sel_valid;
  delay_t     sel_tap;

`ifndef HYPERBUS_DELAY_CAL_OVERRIDE_EN
  logic ovr_unused;
  assign ovr_unused = ^{ovr_en_i, ovr_delay_i};
`endif

  hyperbus_cal_window_sel u_window_sel (
    .mask_i  (pass_mask_o),
    .valid_o (sel_valid),
    .tap_o   (sel_tap)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      tap_idx     <= '0;
      settle_cnt  <= '0;
      sample_cnt  <= '0;
      saved_delay <= DEFAULT_DELAY;
      pass_mask_o <= '0;
      delay_o     <= DEFAULT_DELAY;
      probe_req_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      state       <= state_d;
      tap_idx     <= tap_idx_d;
      settle_cnt  <= settle_cnt_d;
      sample_cnt  <= sample_cnt_d;
      saved_delay <= saved_delay_d;
      pass_mask_o <= mask_d;
      delay_o     <= delay_d;
      probe_req_o <= req_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      error_o     <= error_d;
    end
  end

  always_comb begin
    state_d       = state;
    tap_idx_d     = tap_idx;
    settle_cnt_d  = settle_cnt;
    sample_cnt_d  = sample_cnt;
    saved_delay_d = saved_delay;
    mask_d        = pass_mask_o;
    delay_d       = delay_o;
    req_d         = probe_req_o;
    done_d        = 1'b0;
    error_d       = error_o;

    case (state)
      ST_IDLE: begin
        if (start_i) begin
          mask_d        = '0;
          tap_idx_d     = '0;
          saved_delay_d = delay_o;
          state_d       = ST_APPLY;
        end
`ifdef HYPERBUS_DELAY_CAL_OVERRIDE_EN
        else if (ovr_en_i) begin
          delay_d = ovr_delay_i;
        end
`endif
      end
      ST_APPLY: begin
        delay_d      = tap_idx;
        settle_cnt_d = '0;
        sample_cnt_d = '0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Raise the request together with entering PROBE so a zero-wait PHY answers at once.
        if (settle_cnt == SETTLE_LAST) begin
          req_d   = 1'b1;
          state_d = ST_PROBE;
        end else begin
          settle_cnt_d = settle_cnt + 8'd1;
        end
      end
      ST_PROBE: begin
        if (!probe_req_o) begin
          req_d = 1'b1;
        end else if (probe_valid_i) begin
          req_d = 1'b0;
          if (!probe_pass_i) begin
            state_d = ST_NEXT;
          end else if (sample_cnt == SAMPLES_LAST) begin
            mask_d[tap_idx] = 1'b1;
            state_d         = ST_NEXT;
          end else begin
            sample_cnt_d = sample_cnt + 8'd1;
          end
        end
      end
      ST_NEXT: begin
        if (tap_idx == 2'd3) begin
          state_d = ST_SELECT;
        end else begin
          tap_idx_d = tap_idx + 2'd1;
          state_d   = ST_APPLY;
        end
      end
      ST_SELECT: begin
        // An empty mask restores the tap that was in use before the sweep.
        if (sel_valid) begin
          delay_d = sel_tap;
          error_d = 1'b0;
        end else begin
          delay_d = saved_delay;
          error_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_hyperbus_delay_cal.sv
// Scoreboard bench for hyperbus_delay_cal with a zero-wait PHY model (SETTLE_CYCLES=4, SAMPLES=2).
module tb_hyperbus_delay_cal;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       ovr_en_i;
  logic [1:0] ovr_delay_i;
  logic       probe_req_o;
  logic       probe_valid_i;
  logic       probe_pass_i;
  logic [1:0] delay_o;
  logic       busy_o;
  logic       done_o;
  logic       error_o;
  logic [3:0] pass_mask_o;

  logic [3:0] ws_mask;
  logic       ws_valid;
  logic [1:0] ws_tap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] delay;
    logic       err;
    int         busy;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] pass_tbl = 4'b0000;
  logic [1:0] exp_delay = 2'b01;
  int         req_cnt[4];

  hyperbus_delay_cal #(
    .SETTLE_CYCLES (4),
    .SAMPLES       (2),
    .DEFAULT_DELAY (2'b01)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .ovr_en_i      (ovr_en_i),
    .ovr_delay_i   (ovr_delay_i),
    .probe_req_o   (probe_req_o),
    .probe_valid_i (probe_valid_i),
    .probe_pass_i  (probe_pass_i),
    .delay_o       (delay_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .pass_mask_o   (pass_mask_o)
  );

  hyperbus_cal_window_sel u_ws (
    .mask_i  (ws_mask),
    .valid_o (ws_valid),
    .tap_o   (ws_tap)
  );

  always #5 clk = ~clk;

  // Zero-wait PHY: answers every request in the cycle it is raised.
  always @(negedge clk) begin
    probe_valid_i = probe_req_o;
    probe_pass_i  = pass_tbl[delay_o];
    if (probe_req_o) req_cnt[delay_o] = req_cnt[delay_o] + 1;
  end

  // Reference: scan runs left to right, return centre tap or -1 when nothing passes.
  function automatic int model_sel(input logic [3:0] m);
    int best_s = 0, best_l = 0, cur_s = 0, cur_l = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (cur_l == 0) cur_s = i;
        cur_l++;
        if (cur_l > best_l) begin
          best_l = cur_l;
          best_s = cur_s;
        end
      end else begin
        cur_l = 0;
      end
    end
    return (best_l == 0) ? -1 : best_s + (best_l - 1) / 2;
  endfunction

  task automatic clear_req_cnt();
    for (int i = 0; i < 4; i++) req_cnt[i] = 0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i     = 1'b0;
    exp_delay = 2'b01;
    @(negedge clk);
  endtask

  task automatic run_cal(input logic [3:0] tbl, input string name);
    exp_t e;
    int   t;
    int   busy_cnt;
    bit   got;
    t      = model_sel(tbl);
    e.mask = tbl;
    e.err  = (t < 0);
    e.delay = (t < 0) ? exp_delay : 2'(t);
    e.busy = 1;
    for (int i = 0; i < 4; i++) e.busy += tbl[i] ? 9 : 7;
    sb.push_back(e);
    pass_tbl = tbl;
    clear_req_cnt();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    busy_cnt = 0;
    got      = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (busy_o) busy_cnt++;
      if (done_o) got = 1'b1;
      else @(negedge clk);
    end
    ovr_en_i = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: done_o not seen within 400 cycles", name);
    end
    e = sb.pop_front();
    checks++;
    if (pass_mask_o !== e.mask) begin
      errors++;
      $display("FAIL %s mask: got %b want %b", name, pass_mask_o, e.mask);
    end
    checks++;
    if (delay_o !== e.delay) begin
      errors++;
      $display("FAIL %s delay: got %0d want %0d", name, delay_o, e.delay);
    end
    checks++;
    if (error_o !== e.err) begin
      errors++;
      $display("FAIL %s error: got %b want %b", name, error_o, e.err);
    end
    checks++;
    if (busy_cnt !== e.busy) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, e.busy);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got %b want 0", name, done_o);
    end
    exp_delay = e.delay;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (delay_o !== 2'b01)  begin errors++; $display("FAIL reset delay: got %0d want 1", delay_o); end
    checks++; if (busy_o !== 1'b0)    begin errors++; $display("FAIL reset busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0)    begin errors++; $display("FAIL reset done: got %b want 0", done_o); end
    checks++; if (error_o !== 1'b0)   begin errors++; $display("FAIL reset error: got %b want 0", error_o); end
    checks++; if (pass_mask_o !== 4'b0) begin errors++; $display("FAIL reset mask: got %b want 0000", pass_mask_o); end
    checks++; if (probe_req_o !== 1'b0) begin errors++; $display("FAIL reset req: got %b want 0", probe_req_o); end
  endtask

  task automatic test_window_sel();
    int t;
    for (int m = 0; m < 16; m++) begin
      ws_mask = 4'(m);
      #1;
      t = model_sel(ws_mask);
      checks++;
      if (ws_valid !== (t >= 0) || (t >= 0 && ws_tap !== 2'(t))) begin
        errors++;
        $display("FAIL window_sel mask %b: got valid %b tap %0d want valid %b tap %0d",
                 ws_mask, ws_valid, ws_tap, (t >= 0), t);
      end
    end
  endtask

  task automatic test_basic();
    run_cal(4'b0110, "basic_0110");
  endtask

  task automatic test_windows();
    run_cal(4'b1111, "all_pass");
    run_cal(4'b1011, "mask_1011");
    checks++;
    if (req_cnt[2] !== 1) begin
      errors++;
      $display("FAIL early_exit tap2 requests: got %0d want 1", req_cnt[2]);
    end
    checks++;
    if (req_cnt[3] !== 2) begin
      errors++;
      $display("FAIL early_exit tap3 requests: got %0d want 2", req_cnt[3]);
    end
  endtask

  task automatic test_all_fail();
    apply_reset();
    run_cal(4'b0000, "all_fail");
    run_cal(4'b0110, "recover");
  endtask

  task automatic test_reset_mid();
    bit hit;
    pass_tbl = 4'b1111;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    hit     = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (probe_req_o && delay_o == 2'd2) hit = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid timeout: tap 2 probe not seen");
    end
    #1 rst_i = 1'b1;
    #1;
    checks++; if (delay_o !== 2'b01)    begin errors++; $display("FAIL reset_mid delay: got %0d want 1", delay_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL reset_mid busy: got %b want 0", busy_o); end
    checks++; if (pass_mask_o !== 4'b0) begin errors++; $display("FAIL reset_mid mask: got %b want 0000", pass_mask_o); end
    checks++; if (probe_req_o !== 1'b0) begin errors++; $display("FAIL reset_mid req: got %b want 0", probe_req_o); end
    @(negedge clk);
    rst_i     = 1'b0;
    exp_delay = 2'b01;
    @(negedge clk);
    run_cal(4'b1111, "after_reset");
    checks++;
    if (req_cnt[0] !== 2) begin
      errors++;
      $display("FAIL after_reset tap0 requests: got %0d want 2", req_cnt[0]);
    end
  endtask

  task automatic test_override();
    logic [1:0] want;
    ovr_delay_i = 2'd3;
    ovr_en_i    = 1'b1;
    @(negedge clk);
    ovr_en_i = 1'b0;
`ifdef HYPERBUS_DELAY_CAL_OVERRIDE_EN
    want = 2'd3;
`else
    want = exp_delay;
`endif
    checks++;
    if (delay_o !== want) begin
      errors++;
      $display("FAIL override_idle delay: got %0d want %0d", delay_o, want);
    end
    exp_delay = want;
    // Override held through a sweep must not displace the calibrated tap.
    ovr_delay_i = 2'd2;
    ovr_en_i    = 1'b1;
    run_cal(4'b0011, "override_busy");
  endtask

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    ovr_en_i    = 1'b0;
    ovr_delay_i = 2'd0;
    ws_mask     = 4'b0;
    clear_req_cnt();
    test_reset();
    test_window_sel();
    test_basic();
    test_windows();
    test_all_fail();
    test_reset_mid();
    test_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
